// File: rtl/unary_pkg.sv
// -----------------------------------------------------------------------------
// unary_pkg
//   Shared definitions for the unary arithmetic path: the sequencer state type
//   and the default operand width and phase lengths.
//
//   VAL_W_DEF       default operand width in bits
//   STREAM_LEN_DEF  default read-phase length; also the maximum ones per operand
//   WRITE_LEN_DEF   default write-phase length; long enough for the largest sum
//   seq_state_e     sequencer phases IDLE -> READ -> WRITE -> DONE
// -----------------------------------------------------------------------------
package unary_pkg;

    localparam int VAL_W_DEF      = 4;
    localparam int STREAM_LEN_DEF = (1 << VAL_W_DEF) - 1;
    localparam int WRITE_LEN_DEF  = 2 * STREAM_LEN_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage : unary_pkg

// File: rtl/unary_ones_counter.sv
// -----------------------------------------------------------------------------
// unary_ones_counter
//   Counts the ones on a serial unary stream. The count saturates at its
//   all-ones value instead of wrapping, so an over-long stream reads as
//   "at least max" rather than as a small, wrong number. Also used by the
//   downstream unary-to-binary stage.
//
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset, clears the count
//   en_i     in   1      sample bit_i this cycle
//   clr_i    in   1      synchronous clear; wins over en_i
//   bit_i    in   1      serial unary bit
//   count_o  out  CNT_W  current number of ones seen since the last clear
// -----------------------------------------------------------------------------
module unary_ones_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             bit_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        // NOTE: next-state starts as a copy of the register so every path
        // assigns it; a missing branch would otherwise infer a latch.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && bit_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: flops are written with <= so every register samples the values
    // from before the edge, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : unary_ones_counter

// File: rtl/unary_stream_sequencer.sv
// -----------------------------------------------------------------------------
// unary_stream_sequencer
//   Upstream driver for the unary adder. Takes a pair of binary operands over
//   a valid/ready handshake, plays each one out as a thermometer stream
//   (ones first) during the adder's read phase, then runs the adder's write
//   phase and counts the ones on its dout stream to return the binary sum.
//   One operation is in flight at a time.
//
//   clk            in   1      rising-edge clock
//   rst            in   1      asynchronous active-high reset
//   in_valid       in   1      operand pair valid
//   in_ready       out  1      sequencer is idle and can take an operand pair
//   a_val          in   VAL_W  operand A (binary)
//   b_val          in   VAL_W  operand B (binary)
//   a_bit          out  1      thermometer stream of A to the adder
//   b_bit          out  1      thermometer stream of B to the adder
//   en             out  1      adder enable (high in READ and WRITE)
//   read_or_write  out  1      adder phase select, 0 = read, 1 = write
//   dout           in   1      unary sum stream from the adder
//   sum_valid      out  1      one-cycle pulse, sum_out holds the final sum
//   sum_out        out  CNT_W  ones counted on dout during the write phase
//
//   Timeline after the accept edge: READ for STREAM_LEN cycles, WRITE for
//   WRITE_LEN cycles, DONE for one cycle, then IDLE with in_ready high.
// -----------------------------------------------------------------------------
module unary_stream_sequencer
    import unary_pkg::*;
#(
    parameter int VAL_W      = VAL_W_DEF,
    parameter int STREAM_LEN = (1 << VAL_W) - 1,
    parameter int WRITE_LEN  = 2 * STREAM_LEN,
    parameter int CNT_W      = $clog2(WRITE_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] a_val,
    input  logic [VAL_W-1:0] b_val,
    output logic             a_bit,
    output logic             b_bit,
    output logic             en,
    output logic             read_or_write,
    input  logic             dout,
    output logic             sum_valid,
    output logic [CNT_W-1:0] sum_out
);

    // Common width for comparing the phase counter against an operand; the
    // counter is usually wider, but not if STREAM_LEN is overridden small.
    localparam int CMP_W = (CNT_W > VAL_W) ? CNT_W : VAL_W;

    localparam logic [VAL_W-1:0] OPND_MAX   = VAL_W'(STREAM_LEN);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(STREAM_LEN - 1);
    localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(WRITE_LEN - 1);

    // An operand larger than the read phase cannot be streamed in full, so
    // it is clamped to a stream of all ones.
    function automatic logic [VAL_W-1:0] sat_operand(input logic [VAL_W-1:0] v);
        return (v > OPND_MAX) ? OPND_MAX : v;
    endfunction

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [VAL_W-1:0] a_q;
    logic [VAL_W-1:0] a_d;
    logic [VAL_W-1:0] b_q;
    logic [VAL_W-1:0] b_d;

    logic             a_bit_q;
    logic             a_bit_d;
    logic             b_bit_q;
    logic             b_bit_d;
    logic             en_q;
    logic             en_d;
    logic             rw_q;
    logic             rw_d;
    logic             sum_valid_q;
    logic             sum_valid_d;

    logic             accept;
    logic             sum_en;

    // in_ready is the only combinational output; it is gated by rst so the
    // handshake is dead for the whole reset interval, not just after it.
    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Phase control. A single counter times both READ and WRITE and restarts
    // from zero at every phase change.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = READ;
                    cnt_d   = '0;
                    a_d     = sat_operand(a_val);
                    b_d     = sat_operand(b_val);
                end
            end
            READ: begin
                if (cnt_q == READ_LAST) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                if (cnt_q == WRITE_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Adder-side outputs are decoded from the next state and registered, so
    // each output changes exactly on the edge that enters its phase and no
    // input reaches an output without passing through a flop.
    // -------------------------------------------------------------------------
    always_comb begin
        a_bit_d     = 1'b0;
        b_bit_d     = 1'b0;
        en_d        = 1'b0;
        rw_d        = 1'b0;
        sum_valid_d = 1'b0;

        case (state_d)
            READ: begin
                en_d    = 1'b1;
                // Thermometer code: ones while the counter is below the operand.
                a_bit_d = CMP_W'(cnt_d) < CMP_W'(a_d);
                b_bit_d = CMP_W'(cnt_d) < CMP_W'(b_d);
            end
            WRITE: begin
                en_d = 1'b1;
                rw_d = 1'b1;
            end
            DONE: begin
                sum_valid_d = 1'b1;
            end
            default: begin
                en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            a_bit_q     <= 1'b0;
            b_bit_q     <= 1'b0;
            en_q        <= 1'b0;
            rw_q        <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            a_bit_q     <= a_bit_d;
            b_bit_q     <= b_bit_d;
            en_q        <= en_d;
            rw_q        <= rw_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign a_bit         = a_bit_q;
    assign b_bit         = b_bit_q;
    assign en            = en_q;
    assign read_or_write = rw_q;
    assign sum_valid     = sum_valid_q;

    // -------------------------------------------------------------------------
    // Sum accumulation. dout only counts while in WRITE; the count clears on
    // the accept edge so sum_out keeps the previous result until a new
    // operation actually starts.
    // -------------------------------------------------------------------------
    assign sum_en = (state_q == WRITE);

    unary_ones_counter #(
        .CNT_W (CNT_W)
    ) u_sum_counter (
        .clk     (clk),
        .rst     (rst),
        .en_i    (sum_en),
        .clr_i   (accept),
        .bit_i   (dout),
        .count_o (sum_out)
    );

endmodule : unary_stream_sequencer
